// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving an external 1-bit full adder, LSB first.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic [CW-1:0] cnt;
   logic carry, cmsb;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cmsb   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh   <= a;
               b_sh   <= b;
               carry  <= c_in;
               cnt    <= '0;
               sum_sh <= '0;
               state  <= RUN;
            end
            RUN: begin
               sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_cout;
               // cnt parks at its last value instead of wrapping on the final bit
               if (cnt == LAST) begin
                  cmsb  <= carry;
                  state <= DONE;
               end else
                  cnt <= cnt + CW'(1);
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      fa_a      = state == RUN ? a_sh[0] : 1'b0;
      fa_b      = state == RUN ? b_sh[0] : 1'b0;
      fa_cin    = state == RUN ? carry : 1'b0;
      sum       = state == DONE ? sum_sh : '0;
      c_out     = state == DONE ? carry : 1'b0;
      ovf       = state == DONE ? cmsb ^ carry : 1'b0;
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl with a behavioural full adder.
module tb_serial_add_ctrl;
   localparam int W = 8;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, c_in = 1'b0, out_ready = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic in_ready, out_valid, fa_a, fa_b, fa_cin, fa_sum, fa_cout, c_out, ovf;
   logic [W-1:0] sum;
   int vectors = 0, miscompares = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input int hold, input bit rnd_ready);
      int n;
      chk("in_ready_idle", in_ready, 1);
      a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~ta; b = W'($urandom); c_in = ~tc;
      chk("in_ready_run", in_ready, 0);
      n = 0;
      while (!out_valid && n < 4 * W) begin
         if (rnd_ready) out_ready = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      chk("latency", n, W);
      chk("sum", sum, es);
      chk("c_out", c_out, ec);
      chk("ovf", ovf, eo);
      chk("fa_done", {fa_a, fa_b, fa_cin}, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", {out_valid, in_ready}, 2'b10);
         chk("hold_sum", {sum, c_out, ovf}, {es, ec, eo});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk("idle_after", {in_ready, out_valid}, 2'b10);
      chk("idle_zero", {sum, c_out, ovf, fa_a, fa_b, fa_cin}, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, es;
      logic rc, ec, eo;
      #1;
      chk("reset_hs", {in_ready, out_valid}, 2'b10);
      chk("reset_out", {sum, c_out, ovf, fa_a, fa_b, fa_cin}, 0);
      in_valid = 1'b1; a = 8'h55;
      @(posedge clk); #1;
      chk("reset_ignores_in", {in_ready, out_valid}, 2'b10);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset", {in_ready, out_valid}, 2'b10);

      run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
      run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 5, 1'b0);
      run_op(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);

      a = 8'hFF; b = 8'h01; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("fa_midrun", {fa_a, fa_b, fa_cin}, 3'b101);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_hs", {in_ready, out_valid}, 2'b10);
      chk("async_rst_out", {sum, c_out, ovf, fa_a, fa_b, fa_cin}, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_hold", {in_ready, out_valid, fa_a, fa_b, fa_cin}, 5'b10000);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         {ec, es} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
         run_op(ra, rb, rc, es, ec, eo, $urandom_range(0, 3), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/c_in valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-007 SHALL have port c_in  input  1  initial carry.
REQ-008 SHALL have ports fa_a, fa_b, fa_cin  output  1 each  drive the external 1-bit full adder.
REQ-009 SHALL have ports fa_sum, fa_cout  input  1 each  full-adder results, combinational from fa_a/fa_b/fa_cin.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port c_out  output  1  final carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-017 In IDLE, on an edge with in_valid=1: load a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0, sum_sh<=0, go RUN; in_valid=0 keeps IDLE.
REQ-018 In RUN, fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry; outside RUN all fa_* SHALL be 0.
REQ-019 Each RUN edge: sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1 with zero fill; carry<=fa_cout; cnt<=cnt+1.
REQ-020 On the RUN edge where cnt==WIDTH-1, the block SHALL also capture cmsb<=carry (carry into MSB) and go DONE.
REQ-021 cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap during an operation.
REQ-022 Latency: out_valid SHALL rise exactly WIDTH clock edges after the accepting edge; throughput one result per WIDTH+2 cycles back-to-back.
REQ-023 In DONE, sum=sum_sh, c_out=carry, ovf=cmsb^carry; all three SHALL hold stable until the handshake.
REQ-024 In DONE, edge with out_ready=1 SHALL go IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-025 in_valid SHALL be ignored in RUN and DONE; a/b/c_in changes after acceptance SHALL not affect the result.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 sum, c_out, ovf SHALL read 0 outside DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, cnt, carry, cmsb, a_sh, b_sh, sum_sh to 0, independent of clk.
REQ-029 During and after reset: in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, fa_*=0; inputs ignored while rst_n=0.
REQ-030 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no partial result is ever presented.

Verification (WIDTH=8)
REQ-031 a=8'h05, b=8'h03, c_in=0 -> out_valid exactly 8 edges after accept; sum=8'h08, c_out=0, ovf=0.
REQ-032 a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, ovf=0; a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1, ovf=0.
REQ-033 a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, c_out=1, ovf=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid, sum stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle, then new operands accepted.
REQ-035 rst_n pulsed low after 3 RUN edges -> all outputs 0 asynchronously, in_ready=1; next op a=8'h10, b=8'h20 -> sum=8'h30.
REQ-036 fa_a/fa_b/fa_cin checked 0 in IDLE/DONE; random 1000-operand sweep vs. a+b+c_in reference model with random out_ready.
